// File: rtl/rv32i_types_pkg.sv
// Shared RV32I load/store encodings and the data-memory arbiter state type.
package rv32i_types;

  localparam logic [2:0] LOAD_F3_LB  = 3'b000;
  localparam logic [2:0] LOAD_F3_LH  = 3'b001;
  localparam logic [2:0] LOAD_F3_LW  = 3'b010;
  localparam logic [2:0] LOAD_F3_LBU = 3'b100;
  localparam logic [2:0] LOAD_F3_LHU = 3'b101;

  localparam logic [2:0] STORE_F3_SB = 3'b000;
  localparam logic [2:0] STORE_F3_SH = 3'b001;
  localparam logic [2:0] STORE_F3_SW = 3'b010;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_BUSY_LD = 2'b01,
    ARB_BUSY_ST = 2'b10,
    ARB_ERR     = 2'b11
  } arb_state_e;

  // Loads and stores share the size encoding in funct3[1:0]; funct3[2] marks unsigned loads.
  function automatic logic [1:0] access_size(input logic [2:0] f3);
    return f3[1:0];
  endfunction

endpackage

// File: rtl/ls_align.sv
// Byte-lane helper: access mask, store lane shift, load extract/extend and
// misalignment detection for one byte offset / funct3 pair.
module ls_align
  import rv32i_types::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  mask,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [15:0] rdata_sh;

  always_comb begin
    rdata_sh   = 16'(rdata >> {off, 3'b000});
    wdata_lane = wdata << {off, 3'b000};
    mask       = 4'b1111;
    rdata_ext  = rdata;
    misalign   = 1'b0;
    case (access_size(funct3))
      SZ_BYTE: begin
        mask      = 4'b0001 << off;
        rdata_ext = funct3[2] ? {24'b0, rdata_sh[7:0]}
                              : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      end
      SZ_HALF: begin
        mask      = 4'b0011 << {off[1], 1'b0};
        misalign  = off[0];
        rdata_ext = funct3[2] ? {16'b0, rdata_sh}
                              : {{16{rdata_sh[15]}}, rdata_sh};
      end
      default: begin
        misalign = |off;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the load and store requesters,
// with one outstanding transaction, misalignment trapping and load flush.
module dmem_arbiter
  import rv32i_types::*;
#(
  parameter int STORE_PRIO = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        flush_i,
  input  logic        ld_valid_i,
  output logic        ld_ready_o,
  input  logic [31:0] ld_addr_i,
  input  logic [2:0]  ld_funct3_i,
  output logic        ld_resp_o,
  output logic [31:0] ld_rdata_o,
  output logic        ld_err_o,
  input  logic        st_valid_i,
  output logic        st_ready_o,
  input  logic [31:0] st_addr_i,
  input  logic [2:0]  st_funct3_i,
  input  logic [31:0] st_wdata_i,
  output logic        st_resp_o,
  output logic        st_err_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_rmask_o,
  output logic [3:0]  dmem_wmask_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_resp_i,
  input  logic [31:0] dmem_rdata_i
);

  arb_state_e  state_q, state_d;
  logic        prio_ld_q;
  logic        flushed_q, flushed_d;

  logic        gnt_ld, gnt_st, accept;
  logic [31:0] req_addr;
  logic [2:0]  req_f3;

  logic [29:0] word_p1;
  logic [1:0]  off_p1;
  logic [2:0]  f3_p1;
  logic [31:0] wdata_p1;
  logic        is_st_p1;

  logic [1:0]  al_off;
  logic [2:0]  al_f3;
  logic [3:0]  al_mask;
  logic [31:0] al_wlane;
  logic [31:0] al_rext;
  logic        al_mis;

  // prio_ld_q set means the load side wins the next tie.
  always_comb begin
    gnt_ld = 1'b0;
    gnt_st = 1'b0;
    if (rst_n_i && (state_q == ARB_IDLE) && !flush_i) begin
      if (st_valid_i && ((STORE_PRIO != 0) || !ld_valid_i || !prio_ld_q))
        gnt_st = 1'b1;
      else if (ld_valid_i)
        gnt_ld = 1'b1;
    end
  end

  assign accept     = gnt_ld | gnt_st;
  assign ld_ready_o = gnt_ld;
  assign st_ready_o = gnt_st;
  assign req_addr   = gnt_st ? st_addr_i   : ld_addr_i;
  assign req_f3     = gnt_st ? st_funct3_i : ld_funct3_i;

  // One aligner serves both paths: the granted request while idle, the held one while busy.
  assign al_off = (state_q == ARB_IDLE) ? req_addr[1:0] : off_p1;
  assign al_f3  = (state_q == ARB_IDLE) ? req_f3        : f3_p1;

  ls_align u_align (
    .off       (al_off),
    .funct3    (al_f3),
    .wdata     (wdata_p1),
    .rdata     (dmem_rdata_i),
    .mask      (al_mask),
    .wdata_lane(al_wlane),
    .rdata_ext (al_rext),
    .misalign  (al_mis)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ARB_IDLE;
      prio_ld_q <= 1'b1;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flushed_q <= flushed_d;
      if (accept) prio_ld_q <= gnt_st;
    end
  end

  // ---- p1: request captured on accept, held for the whole transaction ----
  always_ff @(posedge clk_i) begin
    if (accept) begin
      word_p1  <= req_addr[31:2];
      off_p1   <= req_addr[1:0];
      f3_p1    <= req_f3;
      wdata_p1 <= st_wdata_i;
      is_st_p1 <= gnt_st;
    end
  end

  always_comb begin
    state_d      = state_q;
    flushed_d    = 1'b0;
    ld_resp_o    = 1'b0;
    ld_rdata_o   = '0;
    ld_err_o     = 1'b0;
    st_resp_o    = 1'b0;
    st_err_o     = 1'b0;
    dmem_addr_o  = '0;
    dmem_rmask_o = '0;
    dmem_wmask_o = '0;
    dmem_wdata_o = '0;
    case (state_q)
      ARB_IDLE: begin
        if (accept)
          state_d = al_mis ? ARB_ERR : (gnt_st ? ARB_BUSY_ST : ARB_BUSY_LD);
      end
      ARB_BUSY_LD: begin
        dmem_addr_o  = {word_p1, 2'b00};
        dmem_rmask_o = al_mask;
        flushed_d    = flushed_q | flush_i;
        if (dmem_resp_i) begin
          state_d   = ARB_IDLE;
          flushed_d = 1'b0;
          // A flush seen at any point of the load swallows its result.
          if (!(flushed_q || flush_i)) begin
            ld_resp_o  = 1'b1;
            ld_rdata_o = al_rext;
          end
        end
      end
      ARB_BUSY_ST: begin
        dmem_addr_o  = {word_p1, 2'b00};
        dmem_wmask_o = al_mask;
        dmem_wdata_o = al_wlane;
        if (dmem_resp_i) begin
          state_d   = ARB_IDLE;
          st_resp_o = 1'b1;
        end
      end
      ARB_ERR: begin
        state_d = ARB_IDLE;
        if (is_st_p1) begin
          st_resp_o = 1'b1;
          st_err_o  = 1'b1;
        end else if (!flush_i) begin
          ld_resp_o = 1'b1;
          ld_err_o  = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

endmodule
